// File: rtl/ldm_stm_seq_pkg.sv
// rtl/ldm_stm_seq_pkg.sv - shared types and constants for the LDM/STM block-transfer sequencer
package ldm_stm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Addressing modes, indexed by {P,U}
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_IA = 2'b01;
    localparam logic [1:0] MODE_DB = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

    // One register occupies one 32-bit word
    localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/ldm_stm_seq_if.sv
// rtl/ldm_stm_seq_if.sv - memory beat handshake between the sequencer and the memory port
interface ldm_stm_seq_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_we,
        output mem_ack
    );
endinterface

// File: rtl/ldm_stm_seq_scan.sv
// rtl/ldm_stm_seq_scan.sv - lowest-set-bit encoder and popcount over the register list
module reg_list_scan #(
    parameter int NREG  = 16,
    parameter int IDX_W = $clog2(NREG),
    parameter int CNT_W = $clog2(NREG + 1)
) (
    input  logic [NREG-1:0]  list_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic [CNT_W-1:0] count_o
);

    // Walk from the top down so the last hit is the lowest set bit
    always_comb begin
        idx_o   = '0;
        count_o = '0;
        any_o   = |list_i;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        for (int i = 0; i < NREG; i++) begin
            count_o = count_o + CNT_W'(list_i[i]);
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// rtl/ldm_stm_seq.sv - LDM/STM sequencer top; optional abort path under LDM_SEQ_ABORT_EN
module ldm_stm_seq
    import ldm_stm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NREG   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [NREG-1:0]         reg_list_i,
    input  logic [ADDR_W-1:0]       base_i,
    input  logic                    p_bit_i,
    input  logic                    u_bit_i,
    input  logic                    l_bit_i,
    input  logic                    w_bit_i,
    ldm_stm_seq_if.master           mem,
    output logic                    busy_o,
    output logic [$clog2(NREG)-1:0] rf_idx_o,
    output logic                    rf_we_o,
    output logic                    wb_en_o,
    output logic [ADDR_W-1:0]       wb_value_o,
`ifdef LDM_SEQ_ABORT_EN
    input  logic                    mem_abort_i,
    output logic                    aborted_o,
`endif
    output logic                    done_o
);

    localparam int IDX_W = $clog2(NREG);
    localparam int CNT_W = $clog2(NREG + 1);

    state_e            state_q, state_d;
    logic [NREG-1:0]   list_q, list_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wb_value_q, wb_value_d;
    logic              p_q, p_d, u_q, u_d, l_q, l_d, w_q, w_d;
    logic              aborted_q, aborted_d;

    logic [IDX_W-1:0]  scan_idx;
    logic              scan_any;
    logic [CNT_W-1:0]  scan_cnt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] stride;
    logic              abort_hit;

`ifdef LDM_SEQ_ABORT_EN
    assign abort_hit = mem_abort_i;
    assign aborted_o = aborted_q;
`else
    assign abort_hit = 1'b0;
`endif

    reg_list_scan #(.NREG(NREG), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_scan (
        .list_i  (list_q),
        .idx_o   (scan_idx),
        .any_o   (scan_any),
        .count_o (scan_cnt)
    );

    assign stride     = ADDR_W'(WORD_STRIDE);
    assign span       = ADDR_W'(scan_cnt) * stride;
    assign mem.mem_addr = addr_q;
    assign rf_idx_o   = scan_idx;
    assign wb_value_o = wb_value_q;
    assign busy_o     = (state_q != IDLE);

    // Next-state, datapath updates and per-state strobes
    always_comb begin
        state_d     = state_q;
        list_d      = list_q;
        base_d      = base_q;
        addr_d      = addr_q;
        wb_value_d  = wb_value_q;
        p_d         = p_q;
        u_d         = u_q;
        l_d         = l_q;
        w_d         = w_q;
        aborted_d   = aborted_q;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        rf_we_o     = 1'b0;
        wb_en_o     = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    list_d    = reg_list_i;
                    base_d    = base_i;
                    p_d       = p_bit_i;
                    u_d       = u_bit_i;
                    l_d       = l_bit_i;
                    w_d       = w_bit_i;
                    aborted_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                // Beats always walk upward, so decrementing modes start low
                case ({p_q, u_q})
                    MODE_IA: addr_d = base_q;
                    MODE_IB: addr_d = base_q + stride;
                    MODE_DA: addr_d = base_q - span + stride;
                    default: addr_d = base_q - span;
                endcase
                wb_value_d = u_q ? (base_q + span) : (base_q - span);
                state_d    = scan_any ? XFER : FIN;
            end
            XFER: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = ~l_q;
                if (abort_hit) begin
                    aborted_d = 1'b1;
                    state_d   = FIN;
                end else if (mem.mem_ack) begin
                    rf_we_o = l_q;
                    list_d  = list_q & (list_q - NREG'(1));
                    addr_d  = addr_q + stride;
                    if (list_d == '0) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done_o  = 1'b1;
                wb_en_o = w_q & ~aborted_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            list_q     <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            wb_value_q <= '0;
            p_q        <= 1'b0;
            u_q        <= 1'b0;
            l_q        <= 1'b0;
            w_q        <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            wb_value_q <= wb_value_d;
            p_q        <= p_d;
            u_q        <= u_d;
            l_q        <= l_d;
            w_q        <= w_d;
            aborted_q  <= aborted_d;
        end
    end

endmodule
